// File: rtl/config_chain_loader.sv
// config_chain_loader: clears a serial tile configuration chain, then shifts
// exactly CHAIN_LENGTH bits from a word stream into it, LSB first, one bit
// per clock, and flags completion.
// Optional readback of the chain's previous contents is compiled in with the
// macro CONFIG_CHAIN_LOADER_READBACK_EN.
//
// Handshake: a word on in_data transfers on a rising edge where
// in_valid && in_ready are both 1; in_ready does not depend on in_valid, and
// the host may hold in_valid/in_data steady while in_ready is 0.
module config_chain_loader #(
    parameter int CHAIN_LENGTH = 256,
    parameter int WORD_WIDTH   = 8,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  config_data,
    output logic                  config_enable,
    output logic                  config_nreset,
    input  logic                  config_return,
    output logic                  busy,
    output logic                  done,
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    output logic [WORD_WIDTH-1:0] readback_data,
    output logic                  readback_valid,
`endif
    output logic [1:0]            state_dbg
);

    localparam int BCW = $clog2(CHAIN_LENGTH + 1);
    localparam int CCW = $clog2(CLEAR_CYCLES + 1);
    localparam int HW  = $clog2(WORD_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CCW-1:0]        clr_cnt_q, clr_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] sr_q, sr_d;
    logic [HW-1:0]         held_q, held_d;
    logic                  data_q, data_d;

    logic                  shift_w;
    logic                  last_bit_w;
    logic                  accept_w;
    logic [31:0]           needed_w;
    logic [31:0]           held_ext_w;

    // A bit leaves the shift register on every LOAD cycle that holds one.
    assign shift_w    = (state_q == S_LOAD) && (held_q != '0);
    assign last_bit_w = shift_w && (bit_cnt_q == BCW'(CHAIN_LENGTH - 1));
    assign needed_w   = 32'(CHAIN_LENGTH) - 32'(bit_cnt_q);
    assign held_ext_w = 32'(held_q);

    // Refill only when the register is empty or is shifting out its final
    // bit, and only if the chain still wants more than is already held.
    assign in_ready = (state_q == S_LOAD) && (needed_w > held_ext_w) &&
                      ((held_q == '0) || ((held_q == HW'(1)) && shift_w));
    assign accept_w = in_valid && in_ready;

    assign config_enable = shift_w;
    assign config_data   = shift_w ? sr_q[0] : data_q;
    assign config_nreset = (state_q != S_CLEAR);
    assign busy          = (state_q == S_CLEAR) || (state_q == S_LOAD);
    assign done          = (state_q == S_DONE);
    assign state_dbg     = state_q;

    // Next-state logic: sequencing, clear timing, and the shift datapath.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        held_d    = held_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CCW'(CLEAR_CYCLES - 1)) begin
                    state_d   = S_LOAD;
                    bit_cnt_d = '0;
                    held_d    = '0;
                    sr_d      = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CCW'(1);
                end
            end
            S_LOAD: begin
                if (shift_w) begin
                    data_d    = sr_q[0];
                    sr_d      = sr_q >> 1;
                    held_d    = held_q - HW'(1);
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
                if (accept_w) begin
                    sr_d   = in_data;
                    held_d = HW'(WORD_WIDTH);
                end
                // Final chain bit: drop whatever is left of the last word.
                if (last_bit_w) begin
                    state_d = S_DONE;
                    held_d  = '0;
                    sr_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            held_q    <= '0;
            data_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            held_q    <= held_d;
            data_q    <= data_d;
        end
    end

`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    logic [WORD_WIDTH-1:0] rb_word_q, rb_word_d;
    logic [HW-1:0]         rb_cnt_q, rb_cnt_d;
    logic [WORD_WIDTH-1:0] rb_data_q, rb_data_d;
    logic                  rb_valid_q, rb_valid_d;
    logic [WORD_WIDTH-1:0] rb_next_w;

    assign readback_data  = rb_data_q;
    assign readback_valid = rb_valid_q;

    // Collect returned bits LSB first; flush on a full word or the last bit.
    always_comb begin
        rb_next_w  = rb_word_q;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (rb_cnt_q == HW'(i)) rb_next_w[i] = config_return;
        end
        rb_word_d  = rb_word_q;
        rb_cnt_d   = rb_cnt_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        if (shift_w) begin
            if ((rb_cnt_q == HW'(WORD_WIDTH - 1)) || last_bit_w) begin
                rb_data_d  = rb_next_w;
                rb_valid_d = 1'b1;
                rb_word_d  = '0;
                rb_cnt_d   = '0;
            end else begin
                rb_word_d  = rb_next_w;
                rb_cnt_d   = rb_cnt_q + HW'(1);
            end
        end
    end

    // Readback registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rb_word_q  <= '0;
            rb_cnt_q   <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_word_q  <= rb_word_d;
            rb_cnt_q   <= rb_cnt_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end
`else
    logic unused_return_w;
    assign unused_return_w = config_return;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader (CHAIN_LENGTH=20, WORD_WIDTH=8,
// CLEAR_CYCLES=4). The expected bit stream and handshake behaviour come from
// a word-level model: bits are the words' bits LSB first truncated to the
// chain length, and availability is accepted bits minus emitted bits.
module tb_config_chain_loader;
  localparam int CL = 20;
  localparam int WW = 8;
  localparam int CC = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          config_data;
  logic          config_enable;
  logic          config_nreset;
  logic          config_return;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
  logic [WW-1:0] readback_data;
  logic          readback_valid;
  logic [WW-1:0] rb_exp[$];
`endif

  logic [CL-1:0] chain_q = '0;
  logic          exp_q[$];
  logic [WW-1:0] words[$];
  int            checks = 0;
  int            errors = 0;

  // clock / reset
  always #5 clock = ~clock;

  // Chain model: a plain shift register that ignores config_nreset.
  always @(posedge clock) if (config_enable) chain_q <= {chain_q[CL-2:0], config_data};
  assign config_return = chain_q[CL-1];

  config_chain_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW), .CLEAR_CYCLES(CC)) dut (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .config_data(config_data),
    .config_enable(config_enable), .config_nreset(config_nreset),
    .config_return(config_return), .busy(busy), .done(done),
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    .readback_data(readback_data), .readback_valid(readback_valid),
`endif
    .state_dbg(state_dbg));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
  // Readback scoreboard: every pulse must match the next expected word.
  always @(negedge clock) begin
    if (readback_valid) begin
      if (rb_exp.size() == 0) check("rb_extra_pulse", 32'(readback_valid), 32'd0);
      else check("rb_word", 32'(readback_data), 32'(rb_exp.pop_front()));
    end
  end
`endif

  task automatic check_idle_outputs(input string tag, input logic exp_done);
    check({tag, "_enable"}, 32'(config_enable), 32'd0);
    check({tag, "_nreset"}, 32'(config_nreset), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  // One start+clear+load sequence driven from `words`.
  // gap < 0 picks a random idle gap after every accepted word.
  task automatic run_seq(input int gap, input int busy_bit, input int abort_bit);
    int emitted = 0, accepted = 0, gap_cnt = 0, cyc = 0, avail, fill;
    bit exp_ready, pulsed = 0, aborted = 0;
    exp_q.delete();
    foreach (words[w]) for (int b = 0; b < WW; b++) if (exp_q.size() < CL) exp_q.push_back(words[w][b]);
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    begin
      logic [WW-1:0] acc = '0;
      rb_exp.delete();
      for (int k = 0; k < CL; k++) begin
        acc[k % WW] = chain_q[CL-1-k];
        if ((k % WW == WW - 1) || (k == CL - 1)) begin
          rb_exp.push_back(acc);
          acc = '0;
        end
      end
    end
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < CC; c++) begin
      check("clear_nreset", 32'(config_nreset), 32'd0);
      check("clear_enable", 32'(config_enable), 32'd0);
      check("clear_busy", 32'(busy), 32'd1);
      check("clear_done", 32'(done), 32'd0);
      tick();
    end
    while (emitted < CL && cyc < 300) begin
      fill = (accepted * WW < CL) ? accepted * WW : CL;
      avail = fill - emitted;
      exp_ready = ((CL - emitted) > avail) && (avail <= 1);
      check("load_nreset", 32'(config_nreset), 32'd1);
      check("load_busy", 32'(busy), 32'd1);
      check("load_enable", 32'(config_enable), 32'(avail > 0));
      check("load_ready", 32'(in_ready), 32'(exp_ready));
      if (avail > 0) begin
        check("load_bit", 32'(config_data), 32'(exp_q[emitted]));
        emitted++;
      end else if (emitted > 0) begin
        check("stall_hold", 32'(config_data), 32'(exp_q[emitted-1]));
      end
      if (abort_bit >= 0 && emitted == abort_bit) begin
        aborted = 1;
        break;
      end
      start = (busy_bit >= 0 && emitted == busy_bit && !pulsed) ? 1'b1 : 1'b0;
      if (start) pulsed = 1;
      if (accepted < words.size() && gap_cnt == 0) begin
        in_valid = 1'b1;
        in_data  = words[accepted];
      end else begin
        in_valid = 1'b0;
        in_data  = WW'($urandom);
        if (gap_cnt > 0) gap_cnt--;
      end
      if (in_valid && exp_ready) begin
        accepted++;
        gap_cnt = (gap < 0) ? $urandom_range(0, 4) : gap;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (aborted) begin
      reset = 1'b1;
      tick();
      check_idle_outputs("abort", 1'b0);
      check("abort_data", 32'(config_data), 32'd0);
      check("abort_state", 32'(state_dbg), 32'd0);
      reset = 1'b0;
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
      rb_exp.delete();
`endif
      tick();
      return;
    end
    if (cyc >= 300) check("load_timeout", 32'(emitted), 32'(CL));
    check_idle_outputs("done", 1'b1);
    check("done_state", 32'(state_dbg), 32'd3);
    tick();
    check_idle_outputs("done_hold", 1'b1);
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    check("rb_all_seen", 32'(rb_exp.size()), 32'd0);
`endif
  endtask

  initial begin
    // reset state
    tick();
    tick();
    check_idle_outputs("reset", 1'b0);
    check("reset_data", 32'(config_data), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check_idle_outputs("idle", 1'b0);

    // basic back-to-back load
    words = '{8'hA5, 8'h3C, 8'hFF};
    run_seq(0, -1, -1);
    // stalls between words
    run_seq(3, -1, -1);
    // start pulse while busy
    run_seq(0, 5, -1);
    // reset after the ninth bit, then a full sequence
    run_seq(0, -1, 9);
    run_seq(0, -1, -1);
    // reload with zeros (readback returns the previous A5/3C/FF contents)
    words = '{8'h00, 8'h00, 8'h00};
    run_seq(0, -1, -1);
    // randomized words and gaps; the fourth word must never be taken
    for (int r = 0; r < 4; r++) begin
      words.delete();
      for (int w = 0; w < 4; w++) words.push_back(WW'($urandom));
      run_seq(-1, (r == 1) ? int'($urandom_range(1, 18)) : -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
